pll_phase_ctrl: RTL

PLL_PHASE_CTRL -- requirements
Module: pll_phase_ctrl

---
 rtl/pll_phase_ctrl_if.sv | 30 +++
 rtl/pll_phase_ctrl.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/pll_phase_ctrl_if.sv
// pll_phase_ctrl_if
// Command channel between a sequencer and pll_phase_ctrl.
//   cmd_valid  : phase-shift request
//   cmd_ready  : request accepted on a clock edge when valid and ready are both 1
//   cmd_cntsel : PLL output counter to shift
//   cmd_updn   : 1 = advance, 0 = retard
//   cmd_steps  : total phase steps requested
//   busy       : command in progress
//   done       : one-cycle pulse, command completed
//   err        : one-cycle pulse, command aborted
interface pll_phase_ctrl_if;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [4:0]  cmd_cntsel;
   logic        cmd_updn;
   logic [15:0] cmd_steps;
   logic        busy;
   logic        done;
   logic        err;

   modport master (
      output cmd_valid, cmd_cntsel, cmd_updn, cmd_steps,
      input  cmd_ready, busy, done, err
   );

   modport slave (
      input  cmd_valid, cmd_cntsel, cmd_updn, cmd_steps,
      output cmd_ready, busy, done, err
   );
endinterface

// File: rtl/pll_phase_ctrl.sv
// pll_phase_ctrl
// Splits a phase-shift command into bursts of at most G_MAX_BURST steps and
// drives the PLL dynamic phase-shift port (cntsel/updn/num_phase_shifts/phase_en),
// handshaking each burst on the PLL phase_done signal.
//   clk_i                  : controller clock (also the PLL scanclk)
//   rst_n_i                : asynchronous active-low reset
//   cmd                    : command channel (slave side)
//   pll_locked_i           : PLL lock, asynchronous
//   pll_phase_done_i       : PLL phase_done, asynchronous
//   pll_cntsel_o           : PLL counter select
//   pll_num_phase_shifts_o : steps in the current burst
//   pll_updn_o             : PLL shift direction
//   pll_phase_en_o         : PLL phase_en, registered, 2-cycle pulse per burst
//
// state   | meaning
// IDLE    | waiting for a command, ready when lock is up
// SETUP   | burst size and PLL controls presented for one cycle
// PULSE   | phase_en high for two cycles
// WAIT_LO | waiting for phase_done to fall (timed)
// WAIT_HI | waiting for phase_done to rise again (timed)
// NEXT    | retire the burst, finish or start the next one
module pll_phase_ctrl #(
   parameter int G_MAX_BURST = 7,
   parameter int G_TIMEOUT   = 1023
) (
   input  logic                   clk_i,
   input  logic                   rst_n_i,
   pll_phase_ctrl_if.slave        cmd,
   input  logic                   pll_locked_i,
   input  logic                   pll_phase_done_i,
   output logic [4:0]             pll_cntsel_o,
   output logic [2:0]             pll_num_phase_shifts_o,
   output logic                   pll_updn_o,
   output logic                   pll_phase_en_o
);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_SETUP   = 3'd1;
   localparam logic [2:0] S_PULSE   = 3'd2;
   localparam logic [2:0] S_WAIT_LO = 3'd3;
   localparam logic [2:0] S_WAIT_HI = 3'd4;
   localparam logic [2:0] S_NEXT    = 3'd5;

   localparam int TW = $clog2(G_TIMEOUT + 1);

   logic          lock_q1, lock_s;
   logic          pd_q1, pd_s;
   logic [2:0]    state_q, state_d;
   logic [15:0]   rem_q, rem_d;
   logic [2:0]    burst_q, burst_d;
   logic [4:0]    cntsel_q, cntsel_d;
   logic          updn_q, updn_d;
   logic          pe_q, pe_d;
   logic          pcnt_q, pcnt_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic          done_q, done_d;
   logic          err_q, err_d;
   logic          ready_w;
   logic          tmo_hit;
   logic          abort;

   // Burst never exceeds the remaining count, so rem cannot underflow.
   function automatic logic [2:0] f_burst(input logic [15:0] v);
      if (v < 16'(G_MAX_BURST)) return v[2:0];
      else                      return 3'(G_MAX_BURST);
   endfunction

   assign ready_w                = (state_q == S_IDLE) && lock_s;
   assign cmd.cmd_ready          = ready_w;
   assign cmd.busy               = (state_q != S_IDLE);
   assign cmd.done               = done_q;
   assign cmd.err                = err_q;
   assign pll_cntsel_o           = cntsel_q;
   assign pll_updn_o             = updn_q;
   assign pll_num_phase_shifts_o = burst_q;
   assign pll_phase_en_o         = pe_q;

   always_comb begin
      state_d  = state_q;
      rem_d    = rem_q;
      burst_d  = burst_q;
      cntsel_d = cntsel_q;
      updn_d   = updn_q;
      pe_d     = pe_q;
      pcnt_d   = pcnt_q;
      tmo_d    = tmo_q;
      done_d   = 1'b0;
      err_d    = 1'b0;
      tmo_hit  = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (cmd.cmd_valid && ready_w) begin
               cntsel_d = cmd.cmd_cntsel;
               updn_d   = cmd.cmd_updn;
               rem_d    = cmd.cmd_steps;
               if (cmd.cmd_steps == 16'd0) begin
                  done_d = 1'b1;
               end else begin
                  // Burst is registered here so the PLL controls are
                  // already valid throughout SETUP.
                  burst_d = f_burst(cmd.cmd_steps);
                  state_d = S_SETUP;
               end
            end
         end
         S_SETUP: begin
            pe_d    = 1'b1;
            pcnt_d  = 1'b0;
            state_d = S_PULSE;
         end
         S_PULSE: begin
            if (pcnt_q) begin
               pe_d    = 1'b0;
               tmo_d   = '0;
               state_d = S_WAIT_LO;
            end else begin
               pcnt_d = 1'b1;
            end
         end
         S_WAIT_LO: begin
            tmo_d = tmo_q + TW'(1);
            if (!pd_s)                                state_d = S_WAIT_HI;
            else if (tmo_q == TW'(G_TIMEOUT - 1))     tmo_hit = 1'b1;
         end
         S_WAIT_HI: begin
            tmo_d = tmo_q + TW'(1);
            if (pd_s)                                 state_d = S_NEXT;
            else if (tmo_q == TW'(G_TIMEOUT - 1))     tmo_hit = 1'b1;
         end
         S_NEXT: begin
            rem_d = rem_q - {13'd0, burst_q};
            if (rem_d == 16'd0) begin
               done_d  = 1'b1;
               state_d = S_IDLE;
            end else begin
               burst_d = f_burst(rem_d);
               state_d = S_SETUP;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Lock loss or timeout overrides every other transition, including done.
      abort = ((state_q != S_IDLE) && !lock_s) || tmo_hit;
      if (abort) begin
         err_d   = 1'b1;
         done_d  = 1'b0;
         pe_d    = 1'b0;
         rem_d   = '0;
         tmo_d   = '0;
         state_d = S_IDLE;
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         lock_q1  <= 1'b0;
         lock_s   <= 1'b0;
         pd_q1    <= 1'b0;
         pd_s     <= 1'b0;
         state_q  <= S_IDLE;
         rem_q    <= '0;
         burst_q  <= '0;
         cntsel_q <= '0;
         updn_q   <= 1'b0;
         pe_q     <= 1'b0;
         pcnt_q   <= 1'b0;
         tmo_q    <= '0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         lock_q1  <= pll_locked_i;
         lock_s   <= lock_q1;
         pd_q1    <= pll_phase_done_i;
         pd_s     <= pd_q1;
         state_q  <= state_d;
         rem_q    <= rem_d;
         burst_q  <= burst_d;
         cntsel_q <= cntsel_d;
         updn_q   <= updn_d;
         pe_q     <= pe_d;
         pcnt_q   <= pcnt_d;
         tmo_q    <= tmo_d;
         done_q   <= done_d;
         err_q    <= err_d;
      end
   end

endmodule
